// File: rtl/sha256_byte_packer.sv
// Packs a valid/ready byte stream big-endian into 32-bit words for the sha256 core.
// Also reports the message length in bytes alongside the last word.
module sha256_byte_packer #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic [31:0]      word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             word_last,
  output logic [1:0]       word_numbyte,
  output logic [LEN_W-1:0] msg_len
);

  logic             run;
  logic [1:0]       idx;
  logic [23:0]      acc;
  logic [LEN_W-1:0] len_cnt;
  logic             complete, accept, load;
  logic [31:0]      packed_word;

  // Only a word-completing byte needs room in the output register.
  assign complete   = (idx == 2'd3) || byte_last;
  assign byte_ready = run && (!complete || !word_valid || word_ready);
  assign accept     = byte_valid && byte_ready;
  assign load       = accept && complete;

  // Accumulator bytes past idx are always zero, so unused lanes come out zero.
  assign packed_word = {acc, 8'h00} | ({byte_data, 24'h0} >> {idx, 3'b000});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= 2'd0;
      acc     <= 24'h0;
      len_cnt <= '0;
    end else if (accept) begin
      if (complete) begin
        idx <= 2'd0;
        acc <= 24'h0;
      end else begin
        idx <= idx + 2'd1;
        acc <= packed_word[31:8];
      end
      len_cnt <= byte_last ? '0 : len_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_valid   <= 1'b0;
      word_data    <= 32'h0;
      word_last    <= 1'b0;
      word_numbyte <= 2'd0;
      msg_len      <= '0;
    end else if (load) begin
      word_valid   <= 1'b1;
      word_data    <= packed_word;
      word_last    <= byte_last;
      word_numbyte <= idx + 2'd1;
      if (byte_last) msg_len <= len_cnt + LEN_W'(1);
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_byte_packer.sv
// Directed bench for sha256_byte_packer: byte feeder tasks plus a negedge word monitor.
module tb_sha256_byte_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        byte_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_last;
  logic [1:0]  word_numbyte;
  logic [31:0] msg_len;

  int checks = 0;
  int failures = 0;

  sha256_byte_packer #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .word_numbyte(word_numbyte), .msg_len(msg_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  nb;
    logic [31:0] len;
    int          cyc;
  } wrec_t;

  wrec_t wq[$];
  int cyc = 0;
  int vld_cnt = 0;
  int stall_cnt = 0;
  int stab_err = 0;
  int last_hs = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes complete on the posedge following this negedge.
  always @(negedge clk) begin
    if (word_valid) vld_cnt <= vld_cnt + 1;
    if (word_valid && word_ready)
      wq.push_back('{word_data, word_last, word_numbyte, msg_len, cyc});
    if (byte_valid && byte_ready && byte_last) last_hs <= cyc;
    if (byte_valid && !byte_ready) stall_cnt <= stall_cnt + 1;
    if (pv && !pr && word_valid && (word_data !== pd)) stab_err <= stab_err + 1;
    pv <= word_valid;
    pr <= word_ready;
    pd <= word_data;
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    @(negedge clk);
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h byte_ready never asserted", d);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, word_valid, word_last, word_numbyte} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {byte_ready, word_valid, word_last, word_numbyte});
    end
    checks++;
    if ({word_data, msg_len} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", word_data, msg_len);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=0", byte_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (byte_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_edge got=%b exp=1", byte_ready);
    end
  endtask

  task automatic test_abc();
    int b, v;
    word_ready = 1'b1;
    b = wq.size(); v = vld_cnt;
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
    settle();
    checks++;
    if (wq.size() - b !== 1) begin
      failures++; $display("FAIL abc_count got=%0d exp=1", wq.size() - b);
    end else begin
      checks++;
      if (wq[b].d !== 32'h61626300) begin failures++; $display("FAIL abc_data got=%h exp=61626300", wq[b].d); end
      checks++;
      if ({wq[b].l, wq[b].nb} !== 3'b111) begin failures++; $display("FAIL abc_last_nb got=%b exp=111", {wq[b].l, wq[b].nb}); end
      checks++;
      if (wq[b].len !== 32'd3) begin failures++; $display("FAIL abc_len got=%0d exp=3", wq[b].len); end
      checks++;
      if (wq[b].cyc !== last_hs + 1) begin failures++; $display("FAIL abc_latency got=%0d exp=%0d", wq[b].cyc, last_hs + 1); end
    end
    checks++;
    if (vld_cnt - v !== 1) begin
      failures++; $display("FAIL abc_valid_cycles got=%0d exp=1", vld_cnt - v);
    end
  endtask

  task automatic test_multiword();
    int b;
    word_ready = 1'b1;
    b = wq.size();
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0); send(8'hEE, 1'b1);
    settle();
    checks++;
    if (wq.size() - b !== 3) begin
      failures++; $display("FAIL mw_count got=%0d exp=3", wq.size() - b);
    end else begin
      checks++;
      if ({wq[b].d, wq[b].l, wq[b].nb} !== {32'h01020304, 1'b1, 2'd0}) begin
        failures++; $display("FAIL mw_w0 got=%h/%b/%0d exp=01020304/1/0", wq[b].d, wq[b].l, wq[b].nb);
      end
      checks++;
      if (wq[b].len !== 32'd4) begin failures++; $display("FAIL mw_len0 got=%0d exp=4", wq[b].len); end
      checks++;
      if ({wq[b+1].d, wq[b+1].l} !== {32'hAABBCCDD, 1'b0}) begin
        failures++; $display("FAIL mw_w1 got=%h/%b exp=aabbccdd/0", wq[b+1].d, wq[b+1].l);
      end
      checks++;
      if ({wq[b+2].d, wq[b+2].l, wq[b+2].nb} !== {32'hEE000000, 1'b1, 2'd1}) begin
        failures++; $display("FAIL mw_w2 got=%h/%b/%0d exp=ee000000/1/1", wq[b+2].d, wq[b+2].l, wq[b+2].nb);
      end
      checks++;
      if (wq[b+2].len !== 32'd5) begin failures++; $display("FAIL mw_len2 got=%0d exp=5", wq[b+2].len); end
    end
  endtask

  task automatic test_backpressure();
    int b, s, st;
    word_ready = 1'b0;
    b = wq.size(); s = stall_cnt; st = stab_err;
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'(i), (i == 11));
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        word_ready = 1'b1;
      end
    join
    settle();
    checks++;
    if (stall_cnt - s !== 3) begin
      failures++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_cnt - s);
    end
    checks++;
    if (stab_err !== st) begin
      failures++; $display("FAIL bp_stability got=%0d exp=0 changes", stab_err - st);
    end
    checks++;
    if (wq.size() - b !== 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", wq.size() - b);
    end else begin
      checks++;
      if ({wq[b].d, wq[b+1].d, wq[b+2].d} !== {32'h00010203, 32'h04050607, 32'h08090A0B}) begin
        failures++; $display("FAIL bp_data got=%h %h %h exp=00010203 04050607 08090a0b", wq[b].d, wq[b+1].d, wq[b+2].d);
      end
      checks++;
      if ({wq[b].l, wq[b+1].l, wq[b+2].l, wq[b+2].nb} !== 5'b00100) begin
        failures++; $display("FAIL bp_last got=%b exp=00100", {wq[b].l, wq[b+1].l, wq[b+2].l, wq[b+2].nb});
      end
      checks++;
      if (wq[b+2].len !== 32'd12) begin failures++; $display("FAIL bp_len got=%0d exp=12", wq[b+2].len); end
    end
  endtask

  task automatic test_back_to_back();
    int b, c0, s;
    word_ready = 1'b1;
    b = wq.size(); c0 = cyc; s = stall_cnt;
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
    send(8'h11, 1'b0); send(8'h22, 1'b1);
    settle();
    checks++;
    if (last_hs - c0 !== 4 || stall_cnt !== s) begin
      failures++; $display("FAIL b2b_no_gap got=%0d stalls=%0d exp=4 stalls=0", last_hs - c0, stall_cnt - s);
    end
    checks++;
    if (wq.size() - b !== 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", wq.size() - b);
    end else begin
      checks++;
      if ({wq[b].d, wq[b].nb, wq[b].len} !== {32'h61626300, 2'd3, 32'd3}) begin
        failures++; $display("FAIL b2b_w0 got=%h/%0d/%0d exp=61626300/3/3", wq[b].d, wq[b].nb, wq[b].len);
      end
      checks++;
      if ({wq[b+1].d, wq[b+1].l, wq[b+1].nb, wq[b+1].len} !== {32'h11220000, 1'b1, 2'd2, 32'd2}) begin
        failures++; $display("FAIL b2b_w1 got=%h/%b/%0d/%0d exp=11220000/1/2/2", wq[b+1].d, wq[b+1].l, wq[b+1].nb, wq[b+1].len);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b;
    word_ready = 1'b0;
    send(8'hAA, 1'b1);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    b = wq.size();
    checks++;
    if (word_valid !== 1'b1) begin
      failures++; $display("FAIL rm_pending got=%b exp=1", word_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, word_valid, word_last, word_numbyte, word_data, msg_len} !== 69'h0) begin
      failures++; $display("FAIL rm_async_clear got=%b%b%b%0d %h %h exp=all zero",
                           byte_ready, word_valid, word_last, word_numbyte, word_data, msg_len);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    word_ready = 1'b1;
    send(8'h77, 1'b1);
    settle();
    checks++;
    if (wq.size() - b !== 1) begin
      failures++; $display("FAIL rm_count got=%0d exp=1", wq.size() - b);
    end else begin
      checks++;
      if ({wq[b].d, wq[b].l, wq[b].nb, wq[b].len} !== {32'h77000000, 1'b1, 2'd1, 32'd1}) begin
        failures++; $display("FAIL rm_word got=%h/%b/%0d/%0d exp=77000000/1/1/1", wq[b].d, wq[b].l, wq[b].nb, wq[b].len);
      end
    end
  endtask

  task automatic test_sparse();
    int b, v;
    word_ready = 1'b1;
    b = wq.size(); v = vld_cnt;
    send(8'h10, 1'b0); repeat (3) @(posedge clk); #1;
    send(8'h20, 1'b0); repeat (3) @(posedge clk); #1;
    send(8'h30, 1'b0); repeat (3) @(posedge clk); #1;
    send(8'h40, 1'b1);
    settle();
    checks++;
    if (wq.size() - b !== 1 || vld_cnt - v !== 1) begin
      failures++; $display("FAIL sp_count got=%0d words %0d valid cycles exp=1/1", wq.size() - b, vld_cnt - v);
    end else begin
      checks++;
      if ({wq[b].d, wq[b].l, wq[b].nb, wq[b].len} !== {32'h10203040, 1'b1, 2'd0, 32'd4}) begin
        failures++; $display("FAIL sp_word got=%h/%b/%0d/%0d exp=10203040/1/0/4", wq[b].d, wq[b].l, wq[b].nb, wq[b].len);
      end
      checks++;
      if (wq[b].cyc !== last_hs + 1) begin
        failures++; $display("FAIL sp_latency got=%0d exp=%0d", wq[b].cyc, last_hs + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_abc();
    test_multiword();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sparse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
